// File: rtl/serial_field_unpacker.sv
// serial_field_unpacker
//   Bit-serial receiver: collects a variable-length field LSB-first, one bit
//   per accepted beat, widens it to WIDTH bits (sign- or zero-extend) and
//   presents the word on a valid/ready output.
//
// Optional build macro: SERIAL_FIELD_PARITY_EN
//   When defined, every field is followed by one even-parity beat
//   (in_first=0). A mismatch pulses err_frame, but the word is still
//   presented.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset_n    in   synchronous, active-low reset
//   in_valid   in   serial beat present
//   in_bit     in   serial data bit
//   in_first   in   marks the first bit of a field
//   in_ready   out  beat accepted when in_valid && in_ready
//   cfg_len    in   field length (0 or >WIDTH means WIDTH), sampled on first beat
//   cfg_signed in   1 = sign-extend, 0 = zero-extend, sampled with cfg_len
//   out_valid  out  out_data holds a completed word
//   out_ready  in   consumer accepts the word
//   out_data   out  widened field
//   err_frame  out  one-cycle pulse per offending accepted beat
module serial_field_unpacker #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_first,
  output logic             in_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_frame
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
`ifdef SERIAL_FIELD_PARITY_EN
  localparam logic [1:0] PARITY = 2'd3;
`endif

  logic [1:0]       state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] len, len_n;
  logic             sgn, sgn_n;
  logic [WIDTH-1:0] raw, raw_n;
  logic             err_n;
  logic             load;
  logic             acc;
  logic [LEN_W-1:0] eff_len;
`ifdef SERIAL_FIELD_PARITY_EN
  logic             par, par_n;
`endif

  // Keep the low len bits of r; fill the rest with the field's top bit when
  // signed, zeros otherwise. len==WIDTH leaves nothing to fill.
  function automatic logic [WIDTH-1:0] widen(input logic [WIDTH-1:0] r,
                                             input logic [LEN_W-1:0] l,
                                             input logic             s);
    logic             sb;
    logic [WIDTH-1:0] w;
    sb = 1'b0;
    w  = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (LEN_W'(i + 1) == l) sb = r[i];
    for (int unsigned i = 0; i < WIDTH; i++)
      w[i] = (LEN_W'(i) < l) ? r[i] : (s & sb);
    return w;
  endfunction

  assign in_ready  = (state != HOLD) || out_ready;
  assign out_valid = (state == HOLD);
  assign acc       = in_valid && in_ready;
  assign eff_len   = ((cfg_len == '0) || (cfg_len > LEN_W'(WIDTH))) ?
                     LEN_W'(WIDTH) : cfg_len;

  // A flagged first beat restarts the frame from any state it is accepted
  // in (IDLE, SHIFT/PARITY as an abort, HOLD together with the handshake),
  // so that path is handled once, ahead of the per-state cases.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    sgn_n   = sgn;
    raw_n   = raw;
    err_n   = 1'b0;
    load    = 1'b0;
`ifdef SERIAL_FIELD_PARITY_EN
    par_n   = par;
`endif
    if (acc) begin
      if (in_first) begin
`ifdef SERIAL_FIELD_PARITY_EN
        err_n = (state == SHIFT) || (state == PARITY);
        par_n = in_bit;
`else
        err_n = (state == SHIFT);
`endif
        raw_n    = '0;
        raw_n[0] = in_bit;
        cnt_n    = LEN_W'(1);
        len_n    = eff_len;
        sgn_n    = cfg_signed;
        if (eff_len == LEN_W'(1)) begin
`ifdef SERIAL_FIELD_PARITY_EN
          state_n = PARITY;
`else
          state_n = HOLD;
          load    = 1'b1;
`endif
        end else begin
          state_n = SHIFT;
        end
      end else begin
        case (state)
          SHIFT: begin
            for (int unsigned i = 0; i < WIDTH; i++)
              if (LEN_W'(i) == cnt) raw_n[i] = in_bit;
            cnt_n = cnt + LEN_W'(1);
`ifdef SERIAL_FIELD_PARITY_EN
            par_n = par ^ in_bit;
            if (cnt_n == len) state_n = PARITY;
`else
            if (cnt_n == len) begin
              state_n = HOLD;
              load    = 1'b1;
            end
`endif
          end
`ifdef SERIAL_FIELD_PARITY_EN
          PARITY: begin
            err_n   = (in_bit != par);
            state_n = HOLD;
            load    = 1'b1;
          end
`endif
          default: begin
            // Stray continuation beat with no frame open (IDLE, or HOLD
            // while the word is being consumed): drop it.
            err_n   = 1'b1;
            state_n = IDLE;
          end
        endcase
      end
    end else if ((state == HOLD) && out_ready) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      sgn       <= 1'b0;
      raw       <= '0;
      out_data  <= '0;
      err_frame <= 1'b0;
`ifdef SERIAL_FIELD_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      len       <= len_n;
      sgn       <= sgn_n;
      raw       <= raw_n;
      err_frame <= err_n;
`ifdef SERIAL_FIELD_PARITY_EN
      par       <= par_n;
`endif
      if (load) out_data <= widen(raw_n, len_n, sgn_n);
    end
  end

endmodule

// File: tb/tb_serial_field_unpacker.sv
// Directed, table-driven bench for serial_field_unpacker (WIDTH=8).
// Frames are driven one beat per clock; outputs are sampled #1 after the edge.
module tb_serial_field_unpacker;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid, in_bit, in_first, in_ready;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_signed;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             err_frame;

  int total = 0;
  int bad   = 0;

  serial_field_unpacker #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .cfg_len   (cfg_len),
    .cfg_signed(cfg_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_frame (err_frame)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic             sgn;
    int               nb;     // effective number of bits
    logic [7:0]       bits;   // field, bit 0 sent first
    logic [7:0]       exp;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic first, input logic b);
    in_valid = 1'b1;
    in_first = first;
    in_bit   = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("valid_after_consume", out_valid, 0);
  endtask

  task automatic run_frame(input vec_t t);
    logic p;
    cfg_len    = t.len;
    cfg_signed = t.sgn;
    p = 1'b0;
    for (int i = 0; i < t.nb; i++) begin
      p = p ^ t.bits[i];
      beat(i == 0, t.bits[i]);
      if (i < t.nb - 1) chk("valid_early", out_valid, 0);
    end
`ifdef SERIAL_FIELD_PARITY_EN
    chk("valid_before_parity", out_valid, 0);
    beat(1'b0, p);
`endif
    chk("frame_valid", out_valid, 1);
    chk("frame_data", out_data, t.exp);
    chk("frame_err", err_frame, 0);
    consume();
  endtask

  initial begin
    v[0]  = '{len: 4'd3, sgn: 1'b1, nb: 3, bits: 8'h05, exp: 8'hFD};
    v[1]  = '{len: 4'd3, sgn: 1'b0, nb: 3, bits: 8'h05, exp: 8'h05};
    v[2]  = '{len: 4'd8, sgn: 1'b1, nb: 8, bits: 8'h80, exp: 8'h80};
    v[3]  = '{len: 4'd1, sgn: 1'b1, nb: 1, bits: 8'h01, exp: 8'hFF};
    v[4]  = '{len: 4'd0, sgn: 1'b1, nb: 8, bits: 8'h5A, exp: 8'h5A};
    v[5]  = '{len: 4'd4, sgn: 1'b0, nb: 4, bits: 8'h0A, exp: 8'h0A};
    v[6]  = '{len: 4'd4, sgn: 1'b1, nb: 4, bits: 8'h0A, exp: 8'hFA};
    v[7]  = '{len: 4'd5, sgn: 1'b1, nb: 5, bits: 8'h10, exp: 8'hF0};
    v[8]  = '{len: 4'd9, sgn: 1'b1, nb: 8, bits: 8'hC3, exp: 8'hC3};
    v[9]  = '{len: 4'd1, sgn: 1'b0, nb: 1, bits: 8'h01, exp: 8'h01};
    v[10] = '{len: 4'd2, sgn: 1'b1, nb: 2, bits: 8'h02, exp: 8'hFE};

    reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0;
    cfg_len = '0; cfg_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err_frame, 0);
    chk("rst_ready", in_ready, 1);

    for (int k = 0; k < 11; k++) run_frame(v[k]);

    // Backpressure: word held for 5 cycles, offered beats ignored.
    cfg_len = 4'd3; cfg_signed = 1'b1;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
`ifdef SERIAL_FIELD_PARITY_EN
    beat(1'b0, 1'b1);
`endif
    cfg_len = 4'd1; cfg_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_first = 1'b1; in_bit = 1'b0;
      #0;
      chk("bp_ready", in_ready, 0);
      @(posedge clock);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'hFD);
      chk("bp_err", err_frame, 0);
    end
    // Handshake and new single-bit frame on the same edge.
    out_ready = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_bit = 1'b1;
    #0;
    chk("bp_ready_release", in_ready, 1);
    @(posedge clock);
    #1;
    out_ready = 1'b0; in_valid = 1'b0; in_first = 1'b0;
`ifdef SERIAL_FIELD_PARITY_EN
    chk("b2b_wait_parity", out_valid, 0);
    beat(1'b0, 1'b1);
`endif
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 8'h01);
    consume();

    // Stray continuation beat in IDLE.
    beat(1'b0, 1'b1);
    chk("stray_err", err_frame, 1);
    chk("stray_valid", out_valid, 0);
    @(posedge clock);
    #1;
    chk("stray_err_clear", err_frame, 0);
    chk("stray_no_word", out_valid, 0);

    // Abort after two bits, restart with a signed 4-bit frame of ones.
    cfg_len = 4'd4; cfg_signed = 1'b1;
    beat(1'b1, 1'b0); beat(1'b0, 1'b1);
    beat(1'b1, 1'b1);
    chk("abort_err", err_frame, 1);
    chk("abort_valid", out_valid, 0);
    beat(1'b0, 1'b1);
    chk("abort_err_clear", err_frame, 0);
    beat(1'b0, 1'b1); beat(1'b0, 1'b1);
`ifdef SERIAL_FIELD_PARITY_EN
    beat(1'b0, 1'b0);
`endif
    chk("abort_valid_out", out_valid, 1);
    chk("abort_data", out_data, 8'hFF);
    consume();

    // Reset in the middle of a frame.
    cfg_len = 4'd4; cfg_signed = 1'b1;
    beat(1'b1, 1'b1); beat(1'b0, 1'b1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_err", err_frame, 0);
    beat(1'b0, 1'b1);
    chk("midrst_stale_beat_err", err_frame, 1);
    run_frame(v[1]);

`ifdef SERIAL_FIELD_PARITY_EN
    // Wrong parity still presents the word.
    cfg_len = 4'd3; cfg_signed = 1'b1;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk("par_err", err_frame, 1);
    chk("par_valid", out_valid, 1);
    chk("par_data", out_data, 8'hFD);
    consume();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
